// File: rtl/key_scan_ctrl_pkg.sv
// Shared types and constants for the keyboard scan controller.
// Key state encodings match the {keyQ1,keyQ0} register bits.
package key_scan_ctrl_pkg;

  localparam int KBUS_W = 6;

  typedef enum logic [1:0] {
    KEY_IDLE    = 2'b00,
    KEY_CONFIRM = 2'b01,
    KEY_HELD    = 2'b10,
    KEY_RELCHK  = 2'b11
  } keyState_t;

endpackage

// File: rtl/key_scan_ctrl_if.sv
// Keyboard matrix side bundle of the scan controller.
// The host/bench is master, the controller is slave.
interface key_scan_ctrl_if
  import key_scan_ctrl_pkg::*;
#(
  parameter int W = KBUS_W
) ();

  logic         scanEn;
  logic         kbdEn;
  logic         nKR1;
  logic [W-1:0] kbus;
  logic [W-1:0] kbCode;
  logic         keyIrq;
  logic         keyDown;

  modport master (
    output scanEn, kbdEn, nKR1,
    input  kbus, kbCode, keyIrq, keyDown
  );

  modport slave (
    input  scanEn, kbdEn, nKR1,
    output kbus, kbCode, keyIrq, keyDown
  );

endinterface

// File: rtl/key_scan_ctrl_pla.sv
// KEY_PLA: next-state and load strobes of the debounce FSM.
// Purely combinational; the caller decides when to register.
module key_scan_ctrl_pla
  import key_scan_ctrl_pkg::*;
(
  input  logic iKR1,
  input  logic keyQ0,
  input  logic keyQ1,
  input  logic debComp,
  output logic keyD0,
  output logic keyD1,
  output logic nLdComp,
  output logic nLdKbus
);

  keyState_t cur;
  keyState_t nxt;

  assign cur = keyState_t'({keyQ1, keyQ0});
  assign {keyD1, keyD0} = nxt;

  always_comb begin
    nxt     = cur;
    nLdComp = 1'b1;
    nLdKbus = 1'b1;
    unique case (cur)
      KEY_IDLE: begin
        if (iKR1) begin
          nxt     = KEY_CONFIRM;
          nLdComp = 1'b0;
        end
      end
      KEY_CONFIRM: begin
        if (debComp) begin
          if (iKR1) begin
            nxt     = KEY_HELD;
            nLdKbus = 1'b0;
          end else begin
            nxt = KEY_IDLE;
          end
        end
      end
      KEY_HELD: begin
        if (debComp && !iKR1)
          nxt = KEY_RELCHK;
      end
      KEY_RELCHK: begin
        // re-press before release confirms: back to held, no reload
        if (debComp)
          nxt = iKR1 ? KEY_HELD : KEY_IDLE;
      end
      default: nxt = KEY_IDLE;
    endcase
  end

endmodule

// File: rtl/key_scan_ctrl.sv
// Keyboard scan controller: counter, KR1 sync, compare latch,
// KBCODE register and key IRQ around the KEY_PLA FSM logic.
module key_scan_ctrl
  import key_scan_ctrl_pkg::*;
#(
  parameter int CNT_W       = KBUS_W,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       nReset,
  key_scan_ctrl_if.slave bus
);

  logic [CNT_W-1:0]       cnt, cntNext;
  logic [CNT_W-1:0]       cmpLatch, cmpNext;
  logic [CNT_W-1:0]       kbCodeQ, codeNext;
  logic                   keyIrqQ, irqNext;
  logic [SYNC_STAGES-1:0] sync;
  keyState_t              state, stateNext;

  logic iKR1, debComp;
  logic plaD0, plaD1, nLdComp, nLdKbus;

  assign iKR1    = ~sync[SYNC_STAGES-1];
  assign debComp = (cnt == cmpLatch);

  key_scan_ctrl_pla uPla (
    .iKR1    (iKR1),
    .keyQ0   (state[0]),
    .keyQ1   (state[1]),
    .debComp (debComp),
    .keyD0   (plaD0),
    .keyD1   (plaD1),
    .nLdComp (nLdComp),
    .nLdKbus (nLdKbus)
  );

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    cmpNext   = cmpLatch;
    codeNext  = kbCodeQ;
    irqNext   = 1'b0;
    if (!bus.kbdEn) begin
      stateNext = KEY_IDLE;
    end else if (bus.scanEn) begin
      stateNext = keyState_t'({plaD1, plaD0});
      if (!nLdComp)
        cmpNext = cnt;
      if (!nLdKbus) begin
        codeNext = cnt;
        irqNext  = 1'b1;
      end
      cntNext = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= KEY_IDLE;
      cnt      <= '0;
      cmpLatch <= '0;
      kbCodeQ  <= '0;
      keyIrqQ  <= 1'b0;
      sync     <= '1;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      cmpLatch <= cmpNext;
      kbCodeQ  <= codeNext;
      keyIrqQ  <= irqNext;
      sync     <= {sync[SYNC_STAGES-2:0], bus.nKR1};
    end
  end

  assign bus.kbus    = cnt;
  assign bus.kbCode  = kbCodeQ;
  assign bus.keyIrq  = keyIrqQ;
  assign bus.keyDown = state[1];

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Bench for key_scan_ctrl: matrix model plus a per-strobe
// behavioural debounce model, directed and random scenarios.
module tb_key_scan_ctrl;

  logic        clk = 1'b0;
  logic        nReset;
  logic [63:0] pressed;

  int total = 0;
  int bad   = 0;

  localparam int P_IDLE = 0;
  localparam int P_CONF = 1;
  localparam int P_HELD = 2;
  localparam int P_REL  = 3;

  int mCnt, mCmp, mCode, mPhase, mIrqs;
  int obsIrqs, extraIrqs;

  key_scan_ctrl_if kif ();

  assign kif.nKR1 = ~pressed[kif.kbus];

  key_scan_ctrl #(
    .CNT_W       (6),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (kif)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mCnt   = 0;
    mCmp   = 0;
    mCode  = 0;
    mPhase = P_IDLE;
  endtask

  // One accepted strobe: key seen is the one at the code on kbus
  task automatic modelStep();
    bit key;
    bit deb;
    key = pressed[mCnt];
    deb = (mCnt == mCmp);
    case (mPhase)
      P_IDLE: if (key) begin
        mCmp   = mCnt;
        mPhase = P_CONF;
      end
      P_CONF: if (deb) begin
        if (key) begin
          mCode  = mCnt;
          mIrqs++;
          mPhase = P_HELD;
        end else begin
          mPhase = P_IDLE;
        end
      end
      P_HELD: if (deb && !key) mPhase = P_REL;
      default: if (deb) mPhase = key ? P_HELD : P_IDLE;
    endcase
    mCnt = (mCnt + 1) % 64;
  endtask

  task automatic strobe();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0 && kif.keyIrq === 1'b1) extraIrqs++;
    end
    kif.scanEn = 1'b1;
    @(posedge clk);
    if (kif.kbdEn) modelStep();
    #1 kif.scanEn = 1'b0;
    if (kif.keyIrq === 1'b1) obsIrqs++;
  endtask

  task automatic run(input int n);
    obsIrqs   = 0;
    extraIrqs = 0;
    mIrqs     = 0;
    repeat (n) strobe();
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    kif.kbdEn = 1'b1;
    kif.scanEn = 1'b0;
    pressed = '0;
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (kif.kbus !== 6'h00) begin
      bad++; $display("FAIL rst kbus got %h want 00", kif.kbus);
    end
    if (kif.kbCode !== 6'h00) begin
      bad++; $display("FAIL rst kbCode got %h want 00", kif.kbCode);
    end
    if (kif.keyIrq !== 1'b0) begin
      bad++; $display("FAIL rst keyIrq got %b want 0", kif.keyIrq);
    end
    if (kif.keyDown !== 1'b0) begin
      bad++; $display("FAIL rst keyDown got %b want 0", kif.keyDown);
    end
    @(negedge clk);
    nReset = 1'b1;
    modelReset();
    run(64);
    total += 3;
    if (kif.kbus !== 6'h00) begin
      bad++; $display("FAIL wrap64 kbus got %h want 00", kif.kbus);
    end
    if (obsIrqs != 0 || extraIrqs != 0) begin
      bad++; $display("FAIL noKey irq got %0d want 0", obsIrqs + extraIrqs);
    end
    if (kif.keyDown !== 1'b0) begin
      bad++; $display("FAIL noKey keyDown got %b want 0", kif.keyDown);
    end
  endtask

  task automatic test_bounce();
    pressed[42] = 1'b1;
    run(64);
    pressed = '0;
    run(64);
    total += 3;
    if (obsIrqs != 0 || mIrqs != 0) begin
      bad++; $display("FAIL bounce irq got %0d want 0", obsIrqs);
    end
    if (kif.kbCode !== 6'h00) begin
      bad++; $display("FAIL bounce kbCode got %h want 00", kif.kbCode);
    end
    if (kif.keyDown !== 1'b0 || mPhase != P_IDLE) begin
      bad++; $display("FAIL bounce keyDown got %b want 0", kif.keyDown);
    end
  endtask

  task automatic test_held();
    pressed[42] = 1'b1;
    run(64);
    total += 2;
    if (obsIrqs != 0) begin
      bad++; $display("FAIL pass1 irq got %0d want 0", obsIrqs);
    end
    if (kif.keyDown !== 1'b0) begin
      bad++; $display("FAIL pass1 keyDown got %b want 0", kif.keyDown);
    end
    run(64);
    total += 4;
    if (obsIrqs != 1 || mIrqs != 1) begin
      bad++; $display("FAIL pass2 irq got %0d want 1", obsIrqs);
    end
    if (extraIrqs != 0) begin
      bad++; $display("FAIL pass2 irqWidth got %0d extra want 0", extraIrqs);
    end
    if (kif.kbCode !== 6'h2A) begin
      bad++; $display("FAIL pass2 kbCode got %h want 2a", kif.kbCode);
    end
    if (kif.keyDown !== 1'b1) begin
      bad++; $display("FAIL pass2 keyDown got %b want 1", kif.keyDown);
    end
    run(64);
    total += 2;
    if (obsIrqs != 0 || extraIrqs != 0) begin
      bad++; $display("FAIL pass3 irq got %0d want 0", obsIrqs);
    end
    if (kif.keyDown !== 1'b1) begin
      bad++; $display("FAIL pass3 keyDown got %b want 1", kif.keyDown);
    end
  endtask

  task automatic test_release();
    pressed = '0;
    run(64);
    total += 1;
    if (kif.keyDown !== 1'b1 || mPhase != P_REL) begin
      bad++; $display("FAIL relchk keyDown got %b want 1", kif.keyDown);
    end
    run(64);
    total += 1;
    if (kif.keyDown !== 1'b0) begin
      bad++; $display("FAIL released keyDown got %b want 0", kif.keyDown);
    end
    pressed[42] = 1'b1;
    run(128);
    pressed = '0;
    run(64);
    pressed[42] = 1'b1;
    run(64);
    total += 2;
    if (obsIrqs != 0 || mIrqs != 0) begin
      bad++; $display("FAIL repress irq got %0d want 0", obsIrqs);
    end
    if (kif.keyDown !== 1'b1 || mPhase != P_HELD) begin
      bad++; $display("FAIL repress keyDown got %b want 1", kif.keyDown);
    end
    pressed = '0;
    run(128);
  endtask

  task automatic test_multi();
    pressed[5]  = 1'b1;
    pressed[48] = 1'b1;
    run(128);
    total += 2;
    if (obsIrqs != 1) begin
      bad++; $display("FAIL multi irq got %0d want 1", obsIrqs);
    end
    if (kif.kbCode !== 6'h05) begin
      bad++; $display("FAIL multi kbCode got %h want 05", kif.kbCode);
    end
    pressed = '0;
    run(128);
    run(32);
    pressed[63] = 1'b1;
    run(128);
    total += 3;
    if (obsIrqs != 1 || mIrqs != 1) begin
      bad++; $display("FAIL wrap irq got %0d want 1", obsIrqs);
    end
    if (kif.kbCode !== 6'h3F) begin
      bad++; $display("FAIL wrap kbCode got %h want 3f", kif.kbCode);
    end
    if (kif.kbus !== 6'(mCnt)) begin
      bad++; $display("FAIL wrap kbus got %h want %h", kif.kbus, 6'(mCnt));
    end
    pressed = '0;
    run(128);
  endtask

  task automatic test_midop();
    int n;
    pressed[18] = 1'b1;
    n = 0;
    while (mPhase != P_CONF && n < 70) begin
      strobe();
      n++;
    end
    total += 1;
    if (mPhase != P_CONF) begin
      bad++; $display("FAIL confirm timeout got %0d want %0d", mPhase, P_CONF);
    end
    kif.kbdEn = 1'b0;
    mPhase = P_IDLE;
    run(8);
    total += 3;
    if (kif.kbus !== 6'h13 || mCnt != 19) begin
      bad++; $display("FAIL frozen kbus got %h want 13", kif.kbus);
    end
    if (obsIrqs != 0 || extraIrqs != 0) begin
      bad++; $display("FAIL disabled irq got %0d want 0", obsIrqs);
    end
    if (kif.keyDown !== 1'b0) begin
      bad++; $display("FAIL disabled keyDown got %b want 0", kif.keyDown);
    end
    kif.kbdEn = 1'b1;
    run(64);
    total += 1;
    if (obsIrqs != mIrqs) begin
      bad++; $display("FAIL reenable irq got %0d want %0d", obsIrqs, mIrqs);
    end
    run(64);
    total += 2;
    if (obsIrqs != 1) begin
      bad++; $display("FAIL redetect irq got %0d want 1", obsIrqs);
    end
    if (kif.kbCode !== 6'h12 || kif.keyDown !== 1'b1) begin
      bad++; $display("FAIL redetect code got %h/%b want 12/1",
                      kif.kbCode, kif.keyDown);
    end
    @(negedge clk);
    nReset = 1'b0;
    @(posedge clk);
    #1;
    total += 1;
    if ({kif.kbus, kif.kbCode, kif.keyIrq, kif.keyDown} !== 14'h0) begin
      bad++; $display("FAIL midRst got %h/%h/%b/%b want 0",
                      kif.kbus, kif.kbCode, kif.keyIrq, kif.keyDown);
    end
    @(negedge clk);
    nReset = 1'b1;
    pressed = '0;
    modelReset();
  endtask

  task automatic test_random();
    int k;
    for (int seg = 0; seg < 25; seg++) begin
      pressed = '0;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++)
        pressed[$urandom_range(0, 63)] = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        kif.kbdEn = 1'b0;
        mPhase = P_IDLE;
      end else begin
        kif.kbdEn = 1'b1;
      end
      run($urandom_range(1, 150));
      total += 4;
      if (kif.kbus !== 6'(mCnt)) begin
        bad++; $display("FAIL rnd%0d kbus got %h want %h",
                        seg, kif.kbus, 6'(mCnt));
      end
      if (kif.kbCode !== 6'(mCode)) begin
        bad++; $display("FAIL rnd%0d kbCode got %h want %h",
                        seg, kif.kbCode, 6'(mCode));
      end
      if (kif.keyDown !== (mPhase >= P_HELD)) begin
        bad++; $display("FAIL rnd%0d keyDown got %b want %b",
                        seg, kif.keyDown, mPhase >= P_HELD);
      end
      if (obsIrqs != mIrqs || extraIrqs != 0) begin
        bad++; $display("FAIL rnd%0d irq got %0d+%0d want %0d",
                        seg, obsIrqs, extraIrqs, mIrqs);
      end
    end
  endtask

  initial begin
    pressed = '0;
    kif.scanEn = 1'b0;
    kif.kbdEn = 1'b1;
    nReset = 1'b0;
    modelReset();
    test_reset();
    test_bounce();
    test_held();
    test_release();
    test_multi();
    test_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
